dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port 128-byte data SRAM between two requesters.
- Requester 0 is the CPU load/store path and has fixed priority.
- Requester 1 is the debug/DMA port, which gets a starvation guard and a short lock for read-modify-write.
- Sits between the CPU core and the data SRAM; the CPU sees a stall whenever its request is not granted.

Parameters:
- DATA_WIDTH, 8, data bus width in bits.
- D_ADDR_WIDTH, 7, SRAM address width (128 bytes).
- STARVE_LIMIT, 4, consecutive lost cycles after which requester 1 is forced a grant; legal range 1..15.
- LOCK_MAX, 3, maximum cycles requester 1 may hold a lock; legal range 1..7.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  CPU access request.
- m0_we  input  1  CPU write enable (1 = write, 0 = read).
- m0_addr  input  D_ADDR_WIDTH  CPU address.
- m0_wdata  input  DATA_WIDTH  CPU write data.
- m0_gnt  output  1  CPU request accepted this cycle.
- m0_rvalid  output  1  CPU read data valid.
- m0_rdata  output  DATA_WIDTH  CPU read data.
- m1_req, m1_we, m1_addr, m1_wdata  input  1/1/D_ADDR_WIDTH/DATA_WIDTH  debug/DMA request, same meaning as the m0_* inputs.
- m1_lock  input  1  keep ownership after the current grant (read-modify-write).
- m1_gnt, m1_rvalid, m1_rdata  output  1/1/DATA_WIDTH  same meaning as the m0_* outputs.
- mem_cs  output  1  SRAM chip select.
- mem_we  output  1  SRAM write enable.
- mem_addr  output  D_ADDR_WIDTH  SRAM address.
- mem_wdata  output  DATA_WIDTH  SRAM write data.
- mem_rdata  input  DATA_WIDTH  SRAM read data, valid one cycle after mem_cs with mem_we=0.

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE; starve_cnt, lock_cnt, rd_owner and both rvalid outputs clear to 0.
  - While reset is high, m0_gnt, m1_gnt and mem_cs are forced to 0.
- Grant is combinational in the request cycle; the memory access is issued in that same cycle.
- At most one grant per cycle.
- mem_cs = m0_gnt | m1_gnt. mem_we, mem_addr and mem_wdata are muxed from the granted requester; all are 0 when nothing is granted.
- Read latency is 1 cycle:
  - A granted read registers rd_owner.
  - The next cycle, mx_rvalid = 1 for that owner and mx_rdata = mem_rdata.
  - The non-owner's rdata is held at 0.
  - A write produces no rvalid.
- State IDLE:
  - If m0_req and starve_cnt < STARVE_LIMIT: grant requester 0.
  - Else if m1_req: grant requester 1.
  - On a requester 1 grant with m1_lock = 1: go to LOCKED and set lock_cnt = 1.
- State LOCKED:
  - Requester 1 owns the SRAM. m0_gnt = 0 and m1_gnt = m1_req.
  - lock_cnt increments on every cycle spent in LOCKED.
  - Return to IDLE when m1_lock = 0, or m1_req = 0, or lock_cnt == LOCK_MAX (that cycle is still granted).
- starve_cnt:
  - Increments when m1_req = 1 and m1_gnt = 0.
  - Clears whenever m1_gnt = 1 or m1_req = 0.
  - Saturates at STARVE_LIMIT.
- Simultaneous m0_req and m1_req with starve_cnt == STARVE_LIMIT: requester 1 wins for exactly one cycle, then the counter clears.
- A requester dropping req without a grant is legal; nothing is queued.
- Reset asserted mid-lock or with a read in flight: the pending rvalid is suppressed and the state returns to IDLE.

Optional Feature:
- Macro: DMEM_ARB_STARVE_GUARD_EN.
- Defined: the starvation guard operates as described under Behaviour.
- Undefined: starve_cnt logic is absent and requester 0 always wins in IDLE (strict priority). The lock path is unchanged.

Test Plan:
1. Reset, then m0_req=1 read at addr 0x10 with SRAM holding 0xA5 -> m0_gnt=1 the same cycle, mem_addr=0x10, mem_we=0; next cycle m0_rvalid=1, m0_rdata=0xA5, m1_rvalid=0.
2. m1_req=1 alone, write 0x3C to 0x7F -> m1_gnt=1, mem_we=1, mem_addr=0x7F, mem_wdata=0x3C; no rvalid the following cycle.
3. m0_req and m1_req both held high continuously, macro defined, STARVE_LIMIT=4 -> m0_gnt for cycles 1-4, m1_gnt in cycle 5, m0_gnt from cycle 6; macro undefined -> m1_gnt never asserts.
4. m1_req=1 and m1_lock=1 held high with m0_req=1, LOCK_MAX=3 -> m1_gnt for 3 consecutive cycles, m0_gnt=0 throughout, m0_gnt=1 on the 4th cycle.
5. Granted read for requester 1 followed by reset in the next cycle -> m1_rvalid stays 0 and all grants are 0 during reset.
6. Back-to-back reads m0 @0x01 then m1 @0x02 (SRAM values 0x11, 0x22) -> m0_rvalid with 0x11, then m1_rvalid with 0x22, each exactly 1 cycle after its grant.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data SRAM: CPU (m0) has fixed priority, debug/DMA (m1) may lock for RMW.
// Optional starvation guard for m1 is compiled in with `define DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int D_ADDR_WIDTH = 7,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [D_ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [D_ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic                    m1_lock,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    mem_cs,
    output logic                    mem_we,
    output logic [D_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_LOCKED  = 1'b1;
    localparam logic [2:0] LOCK_MAX_C = 3'(LOCK_MAX);

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_starve_limit
        $error("dmem_arbiter: STARVE_LIMIT out of range 1..15");
    end
    if ((LOCK_MAX < 1) || (LOCK_MAX > 7)) begin : g_bad_lock_max
        $error("dmem_arbiter: LOCK_MAX out of range 1..7");
    end

    logic [0:0] state_r;
    logic [0:0] state_nxt_s;
    logic [2:0] lock_cnt_r;
    logic [2:0] lock_cnt_nxt_s;
    logic       m0_ok_s;
    logic       g0_s;
    logic       g1_s;
    logic       rd_pend_r;
    logic       rd_owner_r;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_r;

    assign m0_ok_s = m0_req && (starve_cnt_r < STARVE_LIMIT_C);

    // Count consecutive cycles m1 asks and loses, saturating at the limit
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= 4'd0;
        end else if (g1_s || !m1_req) begin
            starve_cnt_r <= 4'd0;
        end else if (starve_cnt_r < STARVE_LIMIT_C) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign m0_ok_s = m0_req;
`endif

    // Grant decision, made in the request cycle
    always_comb begin
        g0_s = 1'b0;
        g1_s = 1'b0;
        if (reset) begin
            g0_s = 1'b0;
            g1_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    g0_s = m0_ok_s;
                    g1_s = !m0_ok_s && m1_req;
                end
                ST_LOCKED: begin
                    g1_s = m1_req;
                end
                default: begin
                    g0_s = 1'b0;
                    g1_s = 1'b0;
                end
            endcase
        end
    end

    // Lock sequencing; lock_cnt counts owned cycles including the entry grant
    always_comb begin
        state_nxt_s    = state_r;
        lock_cnt_nxt_s = lock_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (g1_s && m1_lock && (LOCK_MAX_C > 3'd1)) begin
                    state_nxt_s    = ST_LOCKED;
                    lock_cnt_nxt_s = 3'd1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                lock_cnt_nxt_s = lock_cnt_r + 3'd1;
                if (!m1_lock || !m1_req || (lock_cnt_r + 3'd1 == LOCK_MAX_C)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                lock_cnt_nxt_s = 3'd0;
            end
        endcase
    end

    // FSM and lock counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            lock_cnt_r <= 3'd0;
        end else begin
            state_r    <= state_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
        end
    end

    // SRAM request mux from the granted requester
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = {D_ADDR_WIDTH{1'b0}};
        mem_wdata = {DATA_WIDTH{1'b0}};
        if (g0_s) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (g1_s) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end else begin
            mem_we    = 1'b0;
        end
    end

    assign mem_cs = g0_s | g1_s;
    assign m0_gnt = g0_s;
    assign m1_gnt = g1_s;

    // Remember which requester owns the read returning next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_r  <= 1'b0;
            rd_owner_r <= 1'b0;
        end else begin
            rd_pend_r <= (g0_s && !m0_we) || (g1_s && !m1_we);
            if ((g0_s && !m0_we) || (g1_s && !m1_we)) begin
                rd_owner_r <= g1_s;
            end else begin
                rd_owner_r <= rd_owner_r;
            end
        end
    end

    // Read return; a reset arriving with a read in flight swallows its rvalid
    always_comb begin
        m0_rvalid = rd_pend_r && !rd_owner_r && !reset;
        m1_rvalid = rd_pend_r && rd_owner_r && !reset;
        if (m0_rvalid) begin
            m0_rdata = mem_rdata;
        end else begin
            m0_rdata = {DATA_WIDTH{1'b0}};
        end
        if (m1_rvalid) begin
            m1_rdata = mem_rdata;
        end else begin
            m1_rdata = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table for the listed scenarios, then random traffic
// checked cycle by cycle against a transaction-level reference model and a behavioural SRAM.
module tb_dmem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int LOCK_MAX     = 3;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [6:0] m0_addr;
    logic [7:0] m0_wdata, m0_rdata;
    logic       m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [6:0] m1_addr;
    logic [7:0] m1_wdata, m1_rdata;
    logic       mem_cs, mem_we;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic [7:0] sram [128];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    bit         m_locked = 1'b0;
    int         m_held   = 0;
    int         m_lost   = 0;
    bit         m_pend   = 1'b0;
    bit         m_owner  = 1'b0;
    logic [7:0] m_data   = 8'h00;

    typedef struct {
        bit rst; bit r0; bit w0; logic [6:0] a0; logic [7:0] d0;
        bit r1; bit w1; logic [6:0] a1; logic [7:0] d1; bit l1;
        bit eg0; bit eg1; bit ev0; logic [7:0] ed0; bit ev1; logic [7:0] ed1;
    } vec_t;

    vec_t tab[$];

    dmem_arbiter #(.DATA_WIDTH(8), .D_ADDR_WIDTH(7), .STARVE_LIMIT(STARVE_LIMIT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // behavioural single-port SRAM, one-cycle read latency
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr];
        end
    end

    function automatic vec_t mk(bit rst, bit r0, bit w0, logic [6:0] a0, logic [7:0] d0,
                                bit r1, bit w1, logic [6:0] a1, logic [7:0] d1, bit l1,
                                bit eg0, bit eg1, bit ev0, logic [7:0] ed0, bit ev1, logic [7:0] ed1);
        vec_t v;
        v = '{rst, r0, w0, a0, d0, r1, w1, a1, d1, l1, eg0, eg1, ev0, ed0, ev1, ed1};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst;
        m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1; m1_lock = v.l1;
    endtask

    // one clock: check at negedge against model (and table row if given), then advance model
    task automatic step(input bit use_tab, input vec_t e);
        bit g0, g1, rv0, rv1, we;
        logic [6:0] ad;
        logic [7:0] wd, rd0, rd1;
        @(negedge clk);
        if (reset) begin
            g0 = 1'b0; g1 = 1'b0;
        end else if (m_locked) begin
            g0 = 1'b0; g1 = m1_req;
        end else begin
            g0 = m0_req && (!GUARD || (m_lost < STARVE_LIMIT));
            g1 = !g0 && m1_req;
        end
        we = g0 ? m0_we    : (g1 ? m1_we    : 1'b0);
        ad = g0 ? m0_addr  : (g1 ? m1_addr  : 7'h00);
        wd = g0 ? m0_wdata : (g1 ? m1_wdata : 8'h00);
        rv0 = !reset && m_pend && !m_owner;
        rv1 = !reset && m_pend && m_owner;
        rd0 = rv0 ? m_data : 8'h00;
        rd1 = rv1 ? m_data : 8'h00;
        chk("m0_gnt", m0_gnt, g0);       chk("m1_gnt", m1_gnt, g1);
        chk("mem_cs", mem_cs, g0 | g1);  chk("mem_we", mem_we, we);
        chk("mem_addr", mem_addr, ad);   chk("mem_wdata", mem_wdata, wd);
        chk("m0_rvalid", m0_rvalid, rv0); chk("m1_rvalid", m1_rvalid, rv1);
        chk("m0_rdata", m0_rdata, rd0);  chk("m1_rdata", m1_rdata, rd1);
        if (use_tab) begin
            chk("tab_m0_gnt", m0_gnt, e.eg0);       chk("tab_m1_gnt", m1_gnt, e.eg1);
            chk("tab_m0_rvalid", m0_rvalid, e.ev0); chk("tab_m0_rdata", m0_rdata, e.ed0);
            chk("tab_m1_rvalid", m1_rvalid, e.ev1); chk("tab_m1_rdata", m1_rdata, e.ed1);
        end
        if (reset) begin
            m_locked = 1'b0; m_held = 0; m_lost = 0; m_pend = 1'b0;
        end else begin
            if (m1_req && !g1) m_lost = (m_lost < STARVE_LIMIT) ? m_lost + 1 : m_lost;
            else               m_lost = 0;
            if (m_locked) begin
                m_held++;
                if (!m1_lock || !m1_req || (m_held == LOCK_MAX)) m_locked = 1'b0;
            end else if (g1 && m1_lock && (LOCK_MAX > 1)) begin
                m_locked = 1'b1; m_held = 1;
            end
            m_pend = (g0 || g1) && !we;
            if (m_pend) begin
                m_owner = g1;
                m_data  = sram[ad];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 128; i++) sram[i] = 8'(i * 7 + 3);
        sram[7'h10] = 8'hA5; sram[7'h01] = 8'h11; sram[7'h02] = 8'h22;
        v = mk(1'b1, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 1'b0,
               1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        drive(v);
        @(posedge clk); #1;

        // reset with requests pending
        tab.push_back(mk(1,1,0,7'h00,8'h00, 1,0,7'h00,8'h00,0, 0,0, 0,8'h00, 0,8'h00));
        tab.push_back(mk(1,0,0,7'h00,8'h00, 0,0,7'h00,8'h00,0, 0,0, 0,8'h00, 0,8'h00));
        // m0 read 0x10, data next cycle
        tab.push_back(mk(0,1,0,7'h10,8'h00, 0,0,7'h00,8'h00,0, 1,0, 0,8'h00, 0,8'h00));
        tab.push_back(mk(0,0,0,7'h00,8'h00, 0,0,7'h00,8'h00,0, 0,0, 1,8'hA5, 0,8'h00));
        // m1 write 0x3C to 0x7F, no rvalid after
        tab.push_back(mk(0,0,0,7'h00,8'h00, 1,1,7'h7F,8'h3C,0, 0,1, 0,8'h00, 0,8'h00));
        tab.push_back(mk(0,0,0,7'h00,8'h00, 0,0,7'h00,8'h00,0, 0,0, 0,8'h00, 0,8'h00));
        // both requesting continuously
        tab.push_back(mk(0,1,0,7'h01,8'h00, 1,0,7'h02,8'h00,0, 1,0, 0,8'h00, 0,8'h00));
        for (int i = 0; i < 3; i++)
            tab.push_back(mk(0,1,0,7'h01,8'h00, 1,0,7'h02,8'h00,0, 1,0, 1,8'h11, 0,8'h00));
        if (GUARD) begin
            tab.push_back(mk(0,1,0,7'h01,8'h00, 1,0,7'h02,8'h00,0, 0,1, 1,8'h11, 0,8'h00));
            tab.push_back(mk(0,1,0,7'h01,8'h00, 1,0,7'h02,8'h00,0, 1,0, 0,8'h00, 1,8'h22));
        end else begin
            tab.push_back(mk(0,1,0,7'h01,8'h00, 1,0,7'h02,8'h00,0, 1,0, 1,8'h11, 0,8'h00));
            tab.push_back(mk(0,1,0,7'h01,8'h00, 1,0,7'h02,8'h00,0, 1,0, 1,8'h11, 0,8'h00));
        end
        tab.push_back(mk(0,0,0,7'h00,8'h00, 0,0,7'h00,8'h00,0, 0,0, 1,8'h11, 0,8'h00));
        // m1 lock: three owned cycles, m0 then gets in
        tab.push_back(mk(0,0,0,7'h00,8'h00, 1,0,7'h02,8'h00,1, 0,1, 0,8'h00, 0,8'h00));
        tab.push_back(mk(0,1,0,7'h01,8'h00, 1,0,7'h02,8'h00,1, 0,1, 0,8'h00, 1,8'h22));
        tab.push_back(mk(0,1,0,7'h01,8'h00, 1,0,7'h02,8'h00,1, 0,1, 0,8'h00, 1,8'h22));
        tab.push_back(mk(0,1,0,7'h01,8'h00, 1,0,7'h02,8'h00,1, 1,0, 0,8'h00, 1,8'h22));
        tab.push_back(mk(0,0,0,7'h00,8'h00, 0,0,7'h00,8'h00,0, 0,0, 1,8'h11, 0,8'h00));
        // m1 read then reset: rvalid suppressed
        tab.push_back(mk(0,0,0,7'h00,8'h00, 1,0,7'h02,8'h00,0, 0,1, 0,8'h00, 0,8'h00));
        tab.push_back(mk(1,1,0,7'h01,8'h00, 1,0,7'h02,8'h00,0, 0,0, 0,8'h00, 0,8'h00));
        tab.push_back(mk(1,0,0,7'h00,8'h00, 0,0,7'h00,8'h00,0, 0,0, 0,8'h00, 0,8'h00));
        // back-to-back reads m0 then m1
        tab.push_back(mk(0,1,0,7'h01,8'h00, 0,0,7'h00,8'h00,0, 1,0, 0,8'h00, 0,8'h00));
        tab.push_back(mk(0,0,0,7'h00,8'h00, 1,0,7'h02,8'h00,0, 0,1, 1,8'h11, 0,8'h00));
        tab.push_back(mk(0,0,0,7'h00,8'h00, 0,0,7'h00,8'h00,0, 0,0, 0,8'h00, 1,8'h22));
        // reset mid-lock returns to idle
        tab.push_back(mk(0,0,0,7'h00,8'h00, 1,0,7'h02,8'h00,1, 0,1, 0,8'h00, 0,8'h00));
        tab.push_back(mk(1,1,0,7'h10,8'h00, 1,0,7'h02,8'h00,1, 0,0, 0,8'h00, 0,8'h00));
        tab.push_back(mk(0,1,0,7'h10,8'h00, 0,0,7'h00,8'h00,0, 1,0, 0,8'h00, 0,8'h00));
        tab.push_back(mk(0,0,0,7'h00,8'h00, 0,0,7'h00,8'h00,0, 0,0, 1,8'hA5, 0,8'h00));

        foreach (tab[i]) begin
            drive(tab[i]);
            step(1'b1, tab[i]);
        end

        for (int n = 0; n < 800; n++) begin
            v.rst = ($urandom_range(0, 39) == 0);
            v.r0  = ($urandom_range(0, 3) != 0);
            v.w0  = $urandom_range(0, 1) == 1;
            v.a0  = 7'($urandom);
            v.d0  = 8'($urandom);
            v.r1  = ($urandom_range(0, 3) != 0);
            v.w1  = $urandom_range(0, 1) == 1;
            v.a1  = 7'($urandom);
            v.d1  = 8'($urandom);
            v.l1  = ($urandom_range(0, 2) != 0);
            drive(v);
            step(1'b0, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
